// File: rtl/div.sv
`timescale 1ns/1ps
// Multicycle 32-bit signed divider: radix-2 restoring division on magnitudes, then sign fix-up.
// Latency: 33 cycles from the start edge to the one-cycle ready pulse; one division per 34 cycles back-to-back.
// Backpressure: none; start is ignored while busy, and a start coincident with ready is accepted.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result,
  output logic [31:0] remainder,
  output logic        exception,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_q;       // quotient shift register, starts as |dividend|
  logic [31:0] r_d;       // |divisor|
  logic [32:0] r_r;       // partial remainder
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;
  logic [31:0] r_result;
  logic [31:0] r_remainder;
  logic        r_exception;
  logic        r_ready;
  logic        r_busy;

  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [33:0] w_rsh;
  logic [33:0] w_diff;
  logic        w_neg;
  logic [31:0] w_q_signed;
  logic [31:0] w_r_signed;

  // Magnitudes as unsigned 32-bit values; 0x80000000 maps to itself without overflow.
  assign w_dvd_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign w_dvs_mag = divisor[31]  ? (~divisor  + 32'd1) : divisor;

  // {R,Q} << 1 seen from the remainder side, and the trial subtraction.
  // R < D < 2^32 holds between iterations, so 34 bits carry the sign of T.
  assign w_rsh  = {r_r, r_q[31]};
  assign w_diff = w_rsh - {2'b00, r_d};
  assign w_neg  = w_diff[33];

  // Sign correction. For divide-by-zero every trial succeeds, so R ends up
  // holding the dividend magnitude and the same fix-up restores the dividend.
  assign w_q_signed = r_neg_q ? (~r_q + 32'd1) : r_q;
  assign w_r_signed = r_neg_r ? (~r_r[31:0] + 32'd1) : r_r[31:0];

  assign result    = r_result;
  assign remainder = r_remainder;
  assign exception = r_exception;
  assign ready     = r_ready;
  assign busy      = r_busy;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: 32 RUN cycles, then one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == 6'd31) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exception <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= w_dvd_mag;
            r_d     <= w_dvs_mag;
            r_r     <= '0;
            r_neg_q <= dividend[31] ^ divisor[31];
            r_neg_r <= dividend[31];
            r_dz    <= (divisor == 32'd0);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_q   <= {r_q[30:0], ~w_neg};
          r_r   <= w_neg ? w_rsh[32:0] : w_diff[32:0];
          r_cnt <= r_cnt + 6'd1;
        end
        DONE: begin
          r_result    <= r_dz ? 32'd0 : w_q_signed;
          r_remainder <= w_r_signed;
          r_exception <= r_dz;
          r_ready     <= 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
`timescale 1ns/1ps
// Self-checking bench for div: reference-model scoreboard plus per-cycle ready/busy/hold checks.
// Latency: expects ready exactly 33 edges after each accepted start.
// Backpressure: models start acceptance (ignored while busy, accepted on the ready cycle).
module tb_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        exception;
  logic        ready;
  logic        busy;

  div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .result    (result),
    .remainder (remainder),
    .exception (exception),
    .ready     (ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          c0       = 0;
  bit          c0_vld   = 1'b0;
  logic [31:0] held_res = '0;
  logic [31:0] held_rem = '0;
  logic        held_exc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Signed division with truncation toward zero; divide-by-zero yields 0 and the dividend.
  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input int due);
    exp_t   e;
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = 0;
      r = sa;
      e.exc = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.exc = 1'b0;
    end
    e.res = q[31:0];
    e.rem = r[31:0];
    e.due = due;
    return e;
  endfunction

  // Acceptance model: a start is taken unless an operation accepted fewer than 34 edges ago is in flight.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      c0_vld = 1'b0;
      sbq.delete();
    end else if (start && (!c0_vld || (cyc - c0) >= 34)) begin
      c0     = cyc;
      c0_vld = 1'b1;
      sbq.push_back(ref_div(dividend, divisor, cyc + 33));
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    logic exp_rdy;
    if (!rst) begin
      chk("rst_result", result, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_exception", {31'd0, exception}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      held_res = '0;
      held_rem = '0;
      held_exc = 1'b0;
    end else begin
      exp_busy = c0_vld && ((cyc - c0) <= 33);
      exp_rdy  = c0_vld && ((cyc - c0) == 33);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      if (ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency_cycle", cyc, e.due);
          chk("result", result, e.res);
          chk("remainder", remainder, e.rem);
          chk("exception", {31'd0, exception}, {31'd0, e.exc});
          held_res = e.res;
          held_rem = e.rem;
          held_exc = e.exc;
        end
      end else begin
        chk("hold_result", result, held_res);
        chk("hold_remainder", remainder, held_rem);
        chk("hold_exception", {31'd0, exception}, {31'd0, held_exc});
        if (sbq.size() > 0 && cyc > sbq[0].due) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout actual=none expected_cyc=%0d cyc=%0d", sbq[0].due, cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((busy || sbq.size() > 0) && n < 80) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy || sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL wait_quiet_timeout actual=busy expected=idle cyc=%0d", cyc);
    end
  endtask

  task automatic run_const(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [31:0] em, input logic ee);
    do_div(a, b);
    wait_quiet();
    chk({nm, "_q"}, result, er);
    chk({nm, "_r"}, remainder, em);
    chk({nm, "_dz"}, {31'd0, exception}, {31'd0, ee});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    rst      = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_const("p100_7",  32'd100,  32'd7,  32'd14,  32'd2,  1'b0);
    run_const("n100_7",  -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
    run_const("p100_n7", 32'd100, -32'sd7, -32'sd14, 32'd2,  1'b0);
    run_const("n100_n7", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);
    run_const("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_const("min_2",   32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0);
    run_const("dz55",    32'd55, 32'd0, 32'd0, 32'd55, 1'b1);
    run_const("p9_3",    32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_const("dzmin",   32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 1'b1);

    // Start during an operation is ignored; start on the ready cycle is accepted.
    do_div(32'd1000, 32'd33);
    repeat (8) @(posedge clk);
    #2;
    dividend = 32'd5;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
    n = 0;
    while (!ready && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("saw_ready", {31'd0, ready}, 32'd1);
    chk("first_q", result, 32'd30);
    dividend = -32'sd77;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
    wait_quiet();
    chk("b2b_q", result, -32'sd15);
    chk("b2b_r", remainder, -32'sd2);

    // Reset mid-operation clears everything at once and suppresses the pending ready.
    do_div(32'd12345, 32'd67);
    repeat (13) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_remainder", remainder, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (40) @(posedge clk);
    run_const("post_rst", 32'd21, -32'sd4, -32'sd5, 32'd1, 1'b0);

    // Randomized signed operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 50)) : -32'($urandom_range(1, 50));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_div(a, b);
      wait_quiet();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
